logical_serial: RTL and testbench

//   Bit-serial, multi-cycle companion to the combinational 8-bit AND/OR logical unit.
//   - Accepts a parallel operand pair and an opcode on a start pulse.
//   - Evaluates one bit per clock, LSB first.
//   - Presents the parallel result behind a valid/ready handshake.

---
 rtl/logical_serial.sv | 100 ++++++++++
 tb/tb_logical_serial.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/logical_serial.sv
// Bit-serial AND/OR unit: evaluates one bit per clock, LSB first, result behind valid/ready.
// Define LOGICAL_SERIAL_XOR_EN to widen op to 2 bits and add XOR/XNOR.
module logical_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef LOGICAL_SERIAL_XOR_EN
    input  logic [1:0]       op,
`else
    input  logic             op,
`endif
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, res, res_next;
    logic [CW-1:0]    idx;
    logic             bit_r, last;
`ifdef LOGICAL_SERIAL_XOR_EN
    logic [1:0]       op_q;
`else
    logic             op_q;
`endif

    // Operands shift right so the current bit is always at position 0.
    always_comb begin
        bit_r = 1'b0;
`ifdef LOGICAL_SERIAL_XOR_EN
        case (op_q)
            2'b00:   bit_r = a_q[0] | b_q[0];
            2'b01:   bit_r = a_q[0] & b_q[0];
            2'b10:   bit_r = a_q[0] ^ b_q[0];
            default: bit_r = ~(a_q[0] ^ b_q[0]);
        endcase
`else
        bit_r = op_q ? (a_q[0] & b_q[0]) : (a_q[0] | b_q[0]);
`endif
        res_next = (res >> 1) | (WIDTH'(bit_r) << (WIDTH - 1));
        last     = (idx == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res       <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        res   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q <= a_q >> 1;
                    b_q <= b_q >> 1;
                    res <= res_next;
                    idx <= idx + CW'(1);
                    if (last) begin
                        y         <= res_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logical_serial.sv
// Table-driven plus randomized bench for logical_serial against a word-level reference model.
module tb_logical_serial;
    localparam int W = 8;
`ifdef LOGICAL_SERIAL_XOR_EN
    localparam int OPW = 2;
`else
    localparam int OPW = 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0, b = '0;
    logic [OPW-1:0] op = '0;
    logic           busy, out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   y;

    int tests = 0;
    int fails = 0;

    logical_serial #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [OPW-1:0] op;
        logic [W-1:0]   exp_y;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference computed on whole words, independent of bit ordering.
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] z,
                                           input logic [OPW-1:0] o);
`ifdef LOGICAL_SERIAL_XOR_EN
        case (o)
            2'b00:   return x | z;
            2'b01:   return x & z;
            2'b10:   return x ^ z;
            default: return ~(x ^ z);
        endcase
`else
        return o[0] ? (x & z) : (x | z);
`endif
    endfunction

    // One full transaction: latency, busy, y hold, backpressure and handshake.
    task automatic run_job(input logic [W-1:0] ja, input logic [W-1:0] jb,
                           input logic [OPW-1:0] jop, input logic [W-1:0] exp,
                           input int hold, input string nm);
        logic [W-1:0] y_prev;
        int cnt;
        @(negedge clk);
        y_prev = y;
        start = 1'b1; a = ja; b = jb; op = jop;
        out_ready = (hold == 0);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); op = OPW'($urandom);
        cnt = 0;
        while (!out_valid && cnt < 4 * W) begin
            check({nm, "_busy"}, 32'(busy), 32'd1);
            check({nm, "_yhold"}, 32'(y), 32'(y_prev));
            @(negedge clk);
            cnt++;
        end
        check({nm, "_latency"}, 32'(cnt), 32'(W));
        check({nm, "_y"}, 32'(y), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({nm, "_bp_valid"}, 32'(out_valid), 32'd1);
            check({nm, "_bp_y"}, 32'(y), 32'(exp));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({nm, "_busy_drop"}, 32'(busy), 32'd0);
        check({nm, "_y_after"}, 32'(y), 32'(exp));
    endtask

    initial begin
        vecs.push_back('{8'hF0, 8'h3C, OPW'(1), 8'h30});
        vecs.push_back('{8'hF0, 8'h3C, OPW'(0), 8'hFC});
        vecs.push_back('{8'h00, 8'h00, OPW'(0), 8'h00});
        vecs.push_back('{8'hFF, 8'h00, OPW'(1), 8'h00});
        vecs.push_back('{8'hFF, 8'h00, OPW'(0), 8'hFF});
        vecs.push_back('{8'hAA, 8'h55, OPW'(0), 8'hFF});
        vecs.push_back('{8'hA5, 8'hA5, OPW'(1), 8'hA5});
        vecs.push_back('{8'h80, 8'h01, OPW'(0), 8'h81});
`ifdef LOGICAL_SERIAL_XOR_EN
        vecs.push_back('{8'hF0, 8'h3C, 2'b10, 8'hCC});
        vecs.push_back('{8'hF0, 8'h3C, 2'b11, 8'h33});
`endif

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_job(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_y, 0, "vec");

        // FC then 00: y must hold FC through the second job's SHIFT
        run_job(8'hF0, 8'h3C, OPW'(0), 8'hFC, 0, "seq_fc");
        run_job(8'h00, 8'h00, OPW'(0), 8'h00, 0, "seq_00");

        run_job(8'hF0, 8'h3C, OPW'(1), 8'h30, 5, "backpressure");

        // Start pulse while busy is ignored
        begin
            int cnt;
            @(negedge clk);
            start = 1'b1; a = 8'hAA; b = 8'h55; op = OPW'(1); out_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (2) @(negedge clk);
            start = 1'b1; a = 8'hFF; b = 8'hFF;
            @(negedge clk);
            start = 1'b0;
            cnt = 0;
            while (!out_valid && cnt < 4 * W) begin
                check("busy_cont", 32'(busy), 32'd1);
                @(negedge clk);
                cnt++;
            end
            check("ign_y", 32'(y), 32'h00);
            @(negedge clk);
            check("ign_valid_drop", 32'(out_valid), 32'd0);
            repeat (3) begin
                @(negedge clk);
                check("ign_no_restart", 32'(busy), 32'd0);
            end
        end

        // Reset in the middle of SHIFT
        begin
            @(negedge clk);
            start = 1'b1; a = 8'hFF; b = 8'hFF; op = OPW'(1); out_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("midrst_busy", 32'(busy), 32'd0);
            check("midrst_valid", 32'(out_valid), 32'd0);
            check("midrst_y", 32'(y), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 2 * W; i++) begin
                @(negedge clk);
                check("midrst_no_valid", 32'(out_valid), 32'd0);
            end
        end

        // Randomized jobs against the model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0]   ra, rb;
            logic [OPW-1:0] ro;
            ra = W'($urandom);
            rb = W'($urandom);
            ro = OPW'($urandom);
            run_job(ra, rb, ro, model(ra, rb, ro), int'($urandom_range(0, 3)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
